// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone (kill/propagate/generate) adder/subtractor with valid/ready on both sides.
// Define PREFIX_ADD_FLAGS_EN to add the ovf and zero outputs.
module prefix_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PREFIX_ADD_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int L  = $clog2(WIDTH);
  localparam int NR = (L + REG_EVERY - 1) / REG_EVERY;

  // Handshake: a beat moves into stage 0 when in_valid & in_ready; the result
  // leaves when out_valid & out_ready. Every stage advances together on en, so
  // in_ready follows out_ready combinationally whenever the output is valid.

  // Stage 0 is the input register; stages 1..NR each follow REG_EVERY prefix levels.
  // KPG pair {kh, kl}: 00 kill, 11 generate, 10 propagate.
  logic [NR:0]      valid_q, valid_d;
  logic [NR:0]      c0_q, c0_d;
  logic [WIDTH-1:0] x_q  [NR+1];
  logic [WIDTH-1:0] x_d  [NR+1];
  logic [WIDTH-1:0] kh_q [NR+1];
  logic [WIDTH-1:0] kh_d [NR+1];
  logic [WIDTH-1:0] kl_q [NR+1];
  logic [WIDTH-1:0] kl_d [NR+1];
`ifdef PREFIX_ADD_FLAGS_EN
  logic [NR:0]      am_q, am_d, bm_q, bm_d;
`endif
  logic             en;
  logic             unused_kh;

  always_comb begin
    logic [WIDTH-1:0] bp, h, l;
    int r, span;
    bp   = sub ? ~b : b;
    h    = '0;
    l    = '0;
    r    = 1;
    span = 1;
    en   = ~valid_q[NR] | out_ready;

    valid_d[0] = in_valid;
    x_d[0]     = a ^ bp;
    kh_d[0]    = a | bp;
    kl_d[0]    = a & bp;
    c0_d[0]    = sub | cin;
`ifdef PREFIX_ADD_FLAGS_EN
    am_d[0]    = a[WIDTH-1];
    bm_d[0]    = bp[WIDTH-1];
`endif

    for (int s = 1; s <= NR; s++) begin
      valid_d[s] = valid_q[s-1];
      x_d[s]     = x_q[s-1];
      kh_d[s]    = kh_q[s-1];
      kl_d[s]    = kl_q[s-1];
      c0_d[s]    = c0_q[s-1];
`ifdef PREFIX_ADD_FLAGS_EN
      am_d[s]    = am_q[s-1];
      bm_d[s]    = bm_q[s-1];
`endif
    end

    // Resolving bit 0 against the carry-in makes every prefix end in kill/generate.
    if (kh_d[1][0] && !kl_d[1][0]) begin
      kh_d[1][0] = c0_q[0];
      kl_d[1][0] = c0_q[0];
    end

    for (int k = 1; k <= L; k++) begin
      r    = (k - 1) / REG_EVERY + 1;
      span = 1 << (k - 1);
      h    = kh_d[r];
      l    = kl_d[r];
      for (int i = span; i < WIDTH; i++) begin
        if (h[i] && !l[i]) begin
          kh_d[r][i] = h[i - span];
          kl_d[r][i] = l[i - span];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      c0_q    <= '0;
`ifdef PREFIX_ADD_FLAGS_EN
      am_q    <= '0;
      bm_q    <= '0;
`endif
      for (int s = 0; s <= NR; s++) begin
        x_q[s]  <= '0;
        kh_q[s] <= '0;
        kl_q[s] <= '0;
      end
    end else if (en) begin
      valid_q <= valid_d;
      c0_q    <= c0_d;
`ifdef PREFIX_ADD_FLAGS_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
`endif
      x_q     <= x_d;
      kh_q    <= kh_d;
      kl_q    <= kl_d;
    end
  end

  // After the last level kl[i] is the carry into bit i+1.
  assign in_ready  = en;
  assign out_valid = valid_q[NR];
  assign sum       = x_q[NR] ^ {kl_q[NR][WIDTH-2:0], c0_q[NR]};
  assign cout      = kl_q[NR][WIDTH-1];
  assign unused_kh = ^kh_q[NR];
`ifdef PREFIX_ADD_FLAGS_EN
  assign zero      = ~|sum;
  assign ovf       = ~(am_q[NR] ^ bm_q[NR]) & (sum[WIDTH-1] ^ am_q[NR]);
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed table, random stream with backpressure,
// stall/reset corners, plus 8-bit/REG_EVERY=1 and 64-bit/REG_EVERY=3 instances.
module tb_prefix_adder_pipe;
  localparam int W = 32;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef PREFIX_ADD_FLAGS_EN
  logic ovf, zero, ovf8, zero8, ovf64, zero64;
  localparam logic [W+2:0] MASK = '1;
`else
  localparam logic [W+2:0] MASK = {2'b00, {(W+1){1'b1}}};
`endif

  logic x_iv, x_cin, x_sub, one;
  logic [7:0] a8, b8, sum8;
  logic [63:0] a64, b64, sum64;
  logic ir8, ov8, cout8, ir64, ov64, cout64;

  always #5 clk = ~clk;

  prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PREFIX_ADD_FLAGS_EN
    , .ovf(ovf), .zero(zero)
`endif
  );

  prefix_adder_pipe #(.WIDTH(8), .REG_EVERY(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(x_iv), .in_ready(ir8), .a(a8), .b(b8),
    .cin(x_cin), .sub(x_sub), .out_valid(ov8), .out_ready(one), .sum(sum8), .cout(cout8)
`ifdef PREFIX_ADD_FLAGS_EN
    , .ovf(ovf8), .zero(zero8)
`endif
  );

  prefix_adder_pipe #(.WIDTH(64), .REG_EVERY(3)) dut64 (
    .clk(clk), .rst(rst), .in_valid(x_iv), .in_ready(ir64), .a(a64), .b(b64),
    .cin(x_cin), .sub(x_sub), .out_valid(ov64), .out_ready(one), .sum(sum64), .cout(cout64)
`ifdef PREFIX_ADD_FLAGS_EN
    , .ovf(ovf64), .zero(zero64)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  int cyc   = 0;
  logic busy;
  logic [W+2:0] exp_q[$];

  typedef struct packed { logic [64:0] r; int stamp; } ent_t;
  ent_t q8[$];
  ent_t q64[$];

  typedef struct {
    logic [W-1:0] a, b;
    logic cin, sub;
    logic [W-1:0] s;
    logic co, ov, z;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: {ovf, zero, cout, sum} from plain wide arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                         input logic fc, input logic fs);
    logic [W-1:0] bp;
    logic [W:0]   r;
    logic         o;
    bp = fs ? ~fb : fb;
    r  = {1'b0, fa} + {1'b0, bp} + {{W{1'b0}}, fs | fc};
    o  = (fa[W-1] == bp[W-1]) && (r[W-1] != fa[W-1]);
    return {o, (r[W-1:0] == '0), r};
  endfunction

  always @(posedge clk) cyc++;

  // Main scoreboard
  always @(negedge clk) begin
    logic [W+2:0] got;
    if (!rst) begin
      check("in_ready_eq_en", in_ready, !out_valid || out_ready);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        n_acc++;
      end
      if (out_valid) begin
`ifdef PREFIX_ADD_FLAGS_EN
        got = {ovf, zero, cout, sum};
`else
        got = {2'b00, cout, sum};
`endif
        if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        else begin
          check("sb_result", got, exp_q[0] & MASK);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Scoreboards for the 8-bit and 64-bit instances (out_ready tied high)
  always @(negedge clk) begin
    ent_t e;
    logic [8:0]  r8;
    logic [64:0] r64;
    if (!rst) begin
      check("w8_in_ready", ir8, 1'b1);
      check("w64_in_ready", ir64, 1'b1);
      if (x_iv) begin
        r8  = {1'b0, a8} + {1'b0, x_sub ? ~b8 : b8} + {8'd0, x_sub | x_cin};
        r64 = {1'b0, a64} + {1'b0, x_sub ? ~b64 : b64} + {64'd0, x_sub | x_cin};
        e.r = {56'd0, r8};  e.stamp = cyc + 1; q8.push_back(e);
        e.r = r64;          e.stamp = cyc + 1; q64.push_back(e);
      end
      if (ov8) begin
        if (q8.size() == 0) check("w8_spurious", ov8, 1'b0);
        else begin
          e = q8.pop_front();
          check("w8_result", {cout8, sum8}, e.r);
          check("w8_latency", cyc - e.stamp, 3);
        end
      end
      if (ov64) begin
        if (q64.size() == 0) check("w64_spurious", ov64, 1'b0);
        else begin
          e = q64.pop_front();
          check("w64_result", {cout64, sum64}, e.r);
          check("w64_latency", cyc - e.stamp, 2);
        end
      end
    end
  end

  task automatic drive_beat(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tc, input logic ts);
    int t;
    t = 0;
    in_valid = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic single(input int idx);
    int n;
    n = 0;
    drive_beat(tbl[idx].a, tbl[idx].b, tbl[idx].cin, tbl[idx].sub);
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, P - 1);
    check("tbl_sum", sum, tbl[idx].s);
    check("tbl_cout", cout, tbl[idx].co);
`ifdef PREFIX_ADD_FLAGS_EN
    check("tbl_ovf", ovf, tbl[idx].ov);
    check("tbl_zero", zero, tbl[idx].z);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    int acc0;
    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};

    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    x_iv = 1'b0; x_cin = 1'b0; x_sub = 1'b0; one = 1'b1;
    a8 = '0; b8 = '0; a64 = '0; b64 = '0; busy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_cout", cout, 1'b0);
`ifdef PREFIX_ADD_FLAGS_EN
    check("rst_zero", zero, 1'b1);
    check("rst_ovf", ovf, 1'b0);
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) single(i);

    // Random stream with pseudo-random backpressure
    busy = 1'b1;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          drive_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        busy = 1'b0;
      end
      begin
        while (busy) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Full pipeline held by out_ready=0, then released
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (4) drive_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    in_valid = 1'b1; a = $urandom; b = $urandom; acc0 = n_acc;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_no_accept", n_acc, acc0);
    repeat (4) begin
      @(negedge clk);
      check("bp_release_burst", out_valid, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    check("bp_after_burst", out_valid, 1'b0);
    drain();

    // Reset with beats in flight
    @(posedge clk);
    #1;
    repeat (3) drive_beat($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_no_ghost", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    single(1);

    // 8-bit (P=4) and 64-bit (P=3) instances: cin=1 sweep, then random add/sub
    for (int i = 0; i < 256; i++) begin
      x_iv = 1'b1; x_cin = 1'b1; x_sub = 1'b0;
      a8 = 8'(i); b8 = 8'($urandom_range(0, 255));
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 300; i++) begin
      x_cin = 1'($urandom_range(0, 1)); x_sub = 1'($urandom_range(0, 1));
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    x_iv = 1'b0;
    repeat (6) @(posedge clk);
    check("w8_drain", q8.size(), 0);
    check("w64_drain", q64.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
